// File: rtl/sweep_ctrl.sv
// sweep_ctrl: FMCW acquisition sequencer; powers the RF front end, arms on ADF4158 ramp start,
// and gates a fixed number of samples per sweep into the packer for a commanded number of sweeps.
module sweep_ctrl #(
  parameter int WARMUP_CYCLES = 4000,
  parameter int SAMPLES       = 1024,
  parameter int ARM_TIMEOUT   = 65535,
  parameter int CNTW          = 16
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic            stop_i,
  input  logic [CNTW-1:0] num_sweeps_i,
  input  logic            adf_cfg_done_i,
  input  logic            adf_muxout_i,
  input  logic            sample_valid_i,
  input  logic            fifo_full_i,
  output logic            pa_off_o,
  output logic            mix_enbl_n_o,
  output logic [1:0]      adc_oe_o,
  output logic [1:0]      adc_shdn_o,
  output logic            capture_en_o,
  output logic            sweep_start_o,
  output logic [CNTW-1:0] sweep_cnt_o,
  output logic            busy_o,
  output logic            drop_o,
  output logic            timeout_o
);
  typedef enum logic [2:0] {IDLE, WARMUP, ARM, CAPTURE, GAP} state_t;
  state_t          r_state, w_next;
  logic [1:0]      r_rst_s;
  logic [2:0]      r_mux;
  logic [CNTW-1:0] r_cnt, r_num;
  logic            r_stop_pend;
  logic            w_rst_n, w_rise, w_fall, w_start, w_go, w_last, w_done, w_tmo;

  // reset asserts immediately but releases on a clock edge
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) r_rst_s <= '0;
    else r_rst_s <= {r_rst_s[0], 1'b1};

  assign w_rst_n = r_rst_s[1];
  assign w_rise  = r_mux[1] & ~r_mux[2];
  assign w_fall  = ~r_mux[1] & r_mux[2];
  assign w_start = start_i & adf_cfg_done_i & ~stop_i;
  assign w_go    = (r_state == IDLE) & w_start;
  assign w_last  = capture_en_o & sample_valid_i & (r_cnt == CNTW'(SAMPLES - 1));
  assign w_done  = (r_num != '0) & (sweep_cnt_o == r_num);

  always_comb begin
    w_next = r_state;
    w_tmo  = 1'b0;
    case (r_state)
      IDLE:    w_next = w_start ? WARMUP : IDLE;
      WARMUP:  w_next = stop_i ? IDLE : (r_cnt == CNTW'(WARMUP_CYCLES - 1)) ? ARM : WARMUP;
      ARM: begin
        w_tmo  = !stop_i && !w_rise && (r_cnt == CNTW'(ARM_TIMEOUT - 1));
        w_next = (stop_i || w_tmo) ? IDLE : w_rise ? CAPTURE : ARM;
      end
      CAPTURE: w_next = (w_last || w_fall) ? GAP : CAPTURE;
      GAP:     w_next = r_mux[1] ? GAP : (r_stop_pend || stop_i || w_done) ? IDLE : ARM;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge w_rst_n)
    if (!w_rst_n) begin
      r_state       <= IDLE;
      r_mux         <= '0;
      r_cnt         <= '0;
      r_num         <= '0;
      r_stop_pend   <= 1'b0;
      pa_off_o      <= 1'b1;
      mix_enbl_n_o  <= 1'b1;
      adc_oe_o      <= 2'b11;
      adc_shdn_o    <= 2'b11;
      capture_en_o  <= 1'b0;
      sweep_start_o <= 1'b0;
      sweep_cnt_o   <= '0;
      busy_o        <= 1'b0;
      drop_o        <= 1'b0;
      timeout_o     <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_mux         <= {r_mux[1:0], adf_muxout_i};
      r_cnt         <= (w_next != r_state) ? '0 :
                       r_cnt + ((r_state == CAPTURE) ? CNTW'(capture_en_o & sample_valid_i) : CNTW'(1));
      r_num         <= w_go ? num_sweeps_i : r_num;
      r_stop_pend   <= (w_next == IDLE) ? 1'b0 : r_stop_pend | stop_i;
      pa_off_o      <= w_next == IDLE;
      mix_enbl_n_o  <= w_next == IDLE;
      adc_oe_o      <= (w_next == IDLE) ? 2'b11 : 2'b10;
      adc_shdn_o    <= (w_next == IDLE) ? 2'b11 : 2'b10;
      busy_o        <= w_next != IDLE;
      // the strobe cycle of sweep_start_o is not yet gated; capture opens one cycle later
      capture_en_o  <= (r_state == CAPTURE) && (w_next == CAPTURE);
      sweep_start_o <= (r_state == ARM) && (w_next == CAPTURE);
      sweep_cnt_o   <= w_go ? '0 : ((r_state == CAPTURE) && (w_next == GAP)) ? sweep_cnt_o + CNTW'(1) : sweep_cnt_o;
      drop_o        <= w_go ? 1'b0 : drop_o | (capture_en_o & fifo_full_i);
      timeout_o     <= w_go ? 1'b0 : timeout_o | w_tmo;
    end
endmodule

// File: tb/tb_sweep_ctrl.sv
// tb_sweep_ctrl: randomized scenario bench for sweep_ctrl, checked against sweep-level expectations
// (samples per sweep, sweep counts, warmup/timeout cycle positions) computed from the parameters.
module tb_sweep_ctrl;
  localparam int W = 40, S = 16, T = 200, CW = 8;
  localparam logic [5:0]  FE_OFF  = 6'b111111;
  localparam logic [5:0]  FE_ON   = 6'b001010;
  localparam logic [10:0] RST_VEC = 11'b11111100000;

  logic clk_i = 0, rst_n_i = 0, start_i = 0, stop_i = 0, adf_cfg_done_i = 1;
  logic adf_muxout_i = 0, sample_valid_i = 0, fifo_full_i = 0;
  logic [CW-1:0] num_sweeps_i = '0;
  logic pa_off_o, mix_enbl_n_o, capture_en_o, sweep_start_o, busy_o, drop_o, timeout_o;
  logic [1:0] adc_oe_o, adc_shdn_o;
  logic [CW-1:0] sweep_cnt_o;
  int total = 0, bad = 0, n_starts = 0, exp_cnt = 0;

  sweep_ctrl #(.WARMUP_CYCLES(W), .SAMPLES(S), .ARM_TIMEOUT(T), .CNTW(CW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .stop_i(stop_i),
    .num_sweeps_i(num_sweeps_i), .adf_cfg_done_i(adf_cfg_done_i), .adf_muxout_i(adf_muxout_i),
    .sample_valid_i(sample_valid_i), .fifo_full_i(fifo_full_i), .pa_off_o(pa_off_o),
    .mix_enbl_n_o(mix_enbl_n_o), .adc_oe_o(adc_oe_o), .adc_shdn_o(adc_shdn_o),
    .capture_en_o(capture_en_o), .sweep_start_o(sweep_start_o), .sweep_cnt_o(sweep_cnt_o),
    .busy_o(busy_o), .drop_o(drop_o), .timeout_o(timeout_o));

  always #5 clk_i = ~clk_i;
  always @(negedge clk_i) if (sweep_start_o === 1'b1) n_starts++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_run(input int num);
    num_sweeps_i = CW'(num);
    start_i = 1;
    tick;
    start_i = 0;
    num_sweeps_i = CW'($urandom);
    exp_cnt = 0;
  endtask

  // one captured sweep from ARM; the sweep count model advances by one per sweep, modulo 2^CW
  task automatic do_sweep(input bit raise, input int stop_at, input int fall_at, input int full_at);
    int n, extra, g;
    bit seen, fed;
    if (raise) begin
      repeat ($urandom_range(4, 10)) tick;
      adf_muxout_i = 1;
    end
    g = 0;
    while (sweep_start_o !== 1'b1 && g < 50) begin tick; g++; end
    total++;
    if (sweep_start_o !== 1'b1) begin
      bad++; $display("FAIL sweep_start_wait got=0 want=1"); adf_muxout_i = 0; return;
    end
    total++;
    if (capture_en_o !== 1'b0) begin bad++; $display("FAIL capture_with_start got=%b want=0", capture_en_o); end
    sample_valid_i = ($urandom_range(0, 1) != 0);
    tick;
    total++;
    if ({sweep_start_o, capture_en_o} !== 2'b01) begin
      bad++; $display("FAIL start_then_capture got=%b want=01", {sweep_start_o, capture_en_o});
    end
    n = 0; extra = 0; g = 0; seen = 0; fed = 0;
    while (g < 10 * S) begin
      if (capture_en_o === 1'b1) begin
        seen = 1;
        if (n >= S) extra++;
        if (n == fall_at) break;
        fifo_full_i = !fed && n == full_at;
        fed |= fifo_full_i;
        sample_valid_i = ($urandom_range(0, 2) != 0);
        if (sample_valid_i) n++;
        stop_i = sample_valid_i && n == stop_at;
      end else begin
        if (seen) break;
        sample_valid_i = ($urandom_range(0, 1) != 0);
        stop_i = 0;
        fifo_full_i = 0;
      end
      tick; g++;
    end
    sample_valid_i = 0; stop_i = 0; fifo_full_i = 0;
    if (fall_at >= 0) begin
      adf_muxout_i = 0; g = 0;
      while (capture_en_o === 1'b1 && g < 10) begin tick; g++; end
      total++;
      if (g > 4 || capture_en_o !== 1'b0) begin bad++; $display("FAIL fall_latency got=%0d want<=4", g); end
    end else begin
      total++;
      if (n != S || extra != 0) begin bad++; $display("FAIL samples_per_sweep got=%0d extra=%0d want=%0d", n, extra, S); end
    end
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    total++;
    if (sweep_cnt_o !== exp_cnt[CW-1:0]) begin bad++; $display("FAIL sweep_cnt got=%0d want=%0d", sweep_cnt_o, exp_cnt); end
    if (fall_at < 0) begin
      repeat ($urandom_range(2, 6)) tick;
      total++;
      if (busy_o !== 1'b1) begin bad++; $display("FAIL gap_waits_low got=%b want=1", busy_o); end
      adf_muxout_i = 0;
    end
  endtask

  task automatic test_reset;
    rst_n_i = 0;
    repeat (3) tick;
    total++;
    if ({pa_off_o, mix_enbl_n_o, adc_oe_o, adc_shdn_o, capture_en_o, sweep_start_o, busy_o, drop_o, timeout_o} !== RST_VEC
        || sweep_cnt_o !== '0) begin
      bad++; $display("FAIL reset_state got=%b cnt=%0d want=%b cnt=0",
        {pa_off_o, mix_enbl_n_o, adc_oe_o, adc_shdn_o, capture_en_o, sweep_start_o, busy_o, drop_o, timeout_o}, sweep_cnt_o, RST_VEC);
    end
    rst_n_i = 1;
    repeat (4) tick;
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL idle_after_release got=%b want=0", busy_o); end
  endtask

  task automatic test_warmup_run;
    int base;
    base = n_starts;
    start_run(2);
    total++;
    if (busy_o !== 1'b1 || {pa_off_o, mix_enbl_n_o, adc_oe_o, adc_shdn_o} !== FE_ON) begin
      bad++; $display("FAIL front_end_on got=%b busy=%b want=%b busy=1", {pa_off_o, mix_enbl_n_o, adc_oe_o, adc_shdn_o}, busy_o, FE_ON);
    end
    repeat (W - 2) tick;
    adf_muxout_i = 1;
    repeat (2) tick;
    total++;
    if (sweep_start_o !== 1'b0) begin bad++; $display("FAIL warmup_too_short got=1 want=0"); end
    tick;
    total++;
    if (sweep_start_o !== 1'b1) begin bad++; $display("FAIL warmup_exact_arm got=0 want=1"); end
    do_sweep(0, -1, -1, -1);
    do_sweep(1, -1, -1, -1);
    repeat (4) tick;
    total++;
    if (busy_o !== 1'b0 || {pa_off_o, mix_enbl_n_o, adc_oe_o, adc_shdn_o} !== FE_OFF || sweep_cnt_o !== 2) begin
      bad++; $display("FAIL run_end got=busy%b fe%b cnt%0d want=busy0 fe%b cnt2", busy_o, {pa_off_o, mix_enbl_n_o, adc_oe_o, adc_shdn_o}, sweep_cnt_o, FE_OFF);
    end
    total++;
    if (n_starts - base != 2) begin bad++; $display("FAIL run_starts got=%0d want=2", n_starts - base); end
  endtask

  task automatic test_timeout;
    start_run(1);
    repeat (W - 3) tick;
    adf_muxout_i = 1;
    repeat (T + 2) tick;
    total++;
    if (busy_o !== 1'b1 || timeout_o !== 1'b0) begin
      bad++; $display("FAIL timeout_early got=busy%b to%b want=busy1 to0", busy_o, timeout_o);
    end
    tick;
    total++;
    if (busy_o !== 1'b0 || timeout_o !== 1'b1 || {pa_off_o, mix_enbl_n_o, adc_oe_o, adc_shdn_o} !== FE_OFF) begin
      bad++; $display("FAIL timeout_exact got=busy%b to%b want=busy0 to1", busy_o, timeout_o);
    end
    adf_muxout_i = 0;
    repeat (4) tick;
  endtask

  task automatic test_continuous;
    int base, nsw;
    nsw = int'($urandom_range(250, 262));
    base = n_starts;
    start_run(0);
    total++;
    if (timeout_o !== 1'b0) begin bad++; $display("FAIL timeout_cleared got=%b want=0", timeout_o); end
    repeat (W) tick;
    for (int i = 1; i <= nsw; i++) do_sweep(1, (i == nsw) ? int'($urandom_range(1, S - 1)) : -1, -1, -1);
    repeat (4) tick;
    total++;
    if (busy_o !== 1'b0 || sweep_cnt_o !== exp_cnt[CW-1:0] || n_starts - base != nsw) begin
      bad++; $display("FAIL stop_continuous got=busy%b cnt%0d starts%0d want=busy0 cnt%0d starts%0d",
        busy_o, sweep_cnt_o, n_starts - base, nsw % (1 << CW), nsw);
    end
    base = n_starts;
    repeat (4) begin
      adf_muxout_i = 1; repeat (6) tick;
      adf_muxout_i = 0; repeat (6) tick;
    end
    total++;
    if (n_starts != base || busy_o !== 1'b0) begin bad++; $display("FAIL idle_after_stop got=%0d want=0", n_starts - base); end
  endtask

  task automatic test_short;
    start_run(3);
    repeat (W) tick;
    do_sweep(1, -1, int'($urandom_range(2, S - 2)), -1);
    do_sweep(1, -1, -1, -1);
    do_sweep(1, -1, -1, -1);
    repeat (4) tick;
    total++;
    if (busy_o !== 1'b0 || sweep_cnt_o !== 3 || timeout_o !== 1'b0) begin
      bad++; $display("FAIL short_run got=busy%b cnt%0d to%b want=busy0 cnt3 to0", busy_o, sweep_cnt_o, timeout_o);
    end
  endtask

  task automatic test_drop;
    start_run(2);
    fifo_full_i = 1;
    repeat (5) tick;
    fifo_full_i = 0;
    repeat (W - 5) tick;
    do_sweep(1, -1, -1, -1);
    total++;
    if (drop_o !== 1'b0) begin bad++; $display("FAIL drop_outside_capture got=%b want=0", drop_o); end
    do_sweep(1, -1, -1, int'($urandom_range(0, S - 1)));
    total++;
    if (drop_o !== 1'b1) begin bad++; $display("FAIL drop_set got=%b want=1", drop_o); end
    repeat (4) tick;
    adf_cfg_done_i = 0; start_i = 1; tick;
    start_i = 0; adf_cfg_done_i = 1; tick;
    total++;
    if (busy_o !== 1'b0 || drop_o !== 1'b1) begin bad++; $display("FAIL start_no_cfg got=busy%b drop%b want=busy0 drop1", busy_o, drop_o); end
    start_i = 1; stop_i = 1; tick;
    start_i = 0; stop_i = 0; tick;
    total++;
    if (busy_o !== 1'b0 || drop_o !== 1'b1) begin bad++; $display("FAIL start_with_stop got=busy%b drop%b want=busy0 drop1", busy_o, drop_o); end
    start_run(1);
    total++;
    if (busy_o !== 1'b1 || drop_o !== 1'b0) begin bad++; $display("FAIL drop_clear_on_start got=busy%b drop%b want=busy1 drop0", busy_o, drop_o); end
    repeat ($urandom_range(1, W - 3)) tick;
    stop_i = 1; tick; stop_i = 0;
    total++;
    if (busy_o !== 1'b0 || {pa_off_o, mix_enbl_n_o, adc_oe_o, adc_shdn_o} !== FE_OFF) begin
      bad++; $display("FAIL stop_in_warmup got=busy%b want=busy0", busy_o);
    end
    start_run(1);
    repeat (W + int'($urandom_range(1, 50))) tick;
    stop_i = 1; tick; stop_i = 0;
    total++;
    if (busy_o !== 1'b0 || timeout_o !== 1'b0) begin bad++; $display("FAIL stop_in_arm got=busy%b to%b want=busy0 to0", busy_o, timeout_o); end
  endtask

  task automatic test_reset_mid;
    int g, base;
    bit act;
    start_run(2);
    repeat (W) tick;
    do_sweep(1, -1, -1, -1);
    repeat (6) tick;
    adf_muxout_i = 1; g = 0;
    while (capture_en_o !== 1'b1 && g < 20) begin tick; g++; end
    total++;
    if (capture_en_o !== 1'b1) begin bad++; $display("FAIL reach_capture got=0 want=1"); end
    fifo_full_i = 1; sample_valid_i = 1;
    repeat ($urandom_range(1, 4)) tick;
    #3 rst_n_i = 0;
    #1;
    total++;
    if ({pa_off_o, mix_enbl_n_o, adc_oe_o, adc_shdn_o, capture_en_o, sweep_start_o, busy_o, drop_o, timeout_o} !== RST_VEC
        || sweep_cnt_o !== '0) begin
      bad++; $display("FAIL async_reset got=%b cnt=%0d want=%b cnt=0",
        {pa_off_o, mix_enbl_n_o, adc_oe_o, adc_shdn_o, capture_en_o, sweep_start_o, busy_o, drop_o, timeout_o}, sweep_cnt_o, RST_VEC);
    end
    tick;
    fifo_full_i = 0;
    rst_n_i = 1;
    base = n_starts; act = 0;
    repeat (60) begin
      adf_muxout_i = ($urandom_range(0, 7) == 0) ? ~adf_muxout_i : adf_muxout_i;
      sample_valid_i = ($urandom_range(0, 1) != 0);
      tick;
      act |= busy_o | capture_en_o;
    end
    total++;
    if (act || n_starts != base) begin bad++; $display("FAIL quiet_after_reset got=act%b starts%0d want=act0 starts0", act, n_starts - base); end
    adf_muxout_i = 0; sample_valid_i = 0;
  endtask

  initial begin
    test_reset;
    test_warmup_run;
    test_timeout;
    test_continuous;
    test_short;
    test_drop;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
